// File: rtl/ff_comb.sv
// ---------------------------------------------------------------------------
// ff_comb : two-stage pipelined signed multiply-accumulate unit
//
// Every qualified operand pair a*b is added into a running accumulator f.
// Stage 1 registers the operands and their qualifier. Stage 2 forms the full
// signed product, adds it into the accumulator and updates a sticky signed
// overflow flag.
//
// Latency: a sample present before edge N is captured at edge N. Its effect
// on f and valid_out is visible after edge N+1. One sample per cycle, with no
// backpressure.
//
// Build option:
//   MAC_SATURATE_EN - when defined, an overflowing add clamps f to the most
//                     positive or most negative accumulator value instead of
//                     wrapping. The overflow flag is computed from the
//                     unclamped sum and behaves the same in both builds.
//
// Parameters:
//   IN_W   width of the signed operands a and b
//   ACC_W  width of the signed accumulator f (ACC_W >= 2*IN_W)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (priority over everything)
//   a, b       signed two's complement operands
//   valid_in   a/b form a sample this cycle
//   valid_out  one-cycle pulse: f was updated by a sample on the last edge
//   f          registered signed accumulator value
//   overflow   registered sticky signed-overflow flag
// ---------------------------------------------------------------------------
module ff_comb #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             valid_in,
    output logic             valid_out,
    output logic [ACC_W-1:0] f,
    output logic             overflow
);

    localparam int PROD_W = 2 * IN_W;

    // Full signed product of two IN_W operands, sign-extended to ACC_W.
    // Both operands are widened to PROD_W first so the product never
    // truncates. This matters for (-2^(IN_W-1))^2, which needs every bit.
    function automatic logic [ACC_W-1:0] mul_ext(
        input logic [IN_W-1:0] x,
        input logic [IN_W-1:0] y
    );
        logic signed [PROD_W-1:0] xe;
        logic signed [PROD_W-1:0] ye;
        logic signed [PROD_W-1:0] p;
        xe = PROD_W'($signed(x));
        ye = PROD_W'($signed(y));
        p  = xe * ye;
        return ACC_W'(p);
    endfunction

    // Signed add overflow: the addends share a sign and the result's sign
    // differs from it.
    function automatic logic add_ovf(
        input logic [ACC_W-1:0] acc,
        input logic [ACC_W-1:0] prod,
        input logic [ACC_W-1:0] sum
    );
        return (prod[ACC_W-1] == acc[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    endfunction

    // Clamp value for an overflowing add. Overflow only occurs when both
    // addends have the sign of the accumulator, so that sign gives the
    // direction of the overflow.
    function automatic logic [ACC_W-1:0] sat_value(input logic acc_sign);
        logic [ACC_W-1:0] v;
        if (acc_sign) begin
            v = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            v = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return v;
    endfunction

    // Stage 1 registers
    logic [IN_W-1:0]  a_r;
    logic [IN_W-1:0]  b_r;
    logic             v_r;

    // Stage 2 registers (drive the outputs directly)
    logic [ACC_W-1:0] f_r;
    logic             ovf_r;
    logic             vout_r;

    // Stage 2 combinational datapath
    logic [ACC_W-1:0] prod_s;
    logic [ACC_W-1:0] sum_s;
    logic             add_ovf_s;
    logic [ACC_W-1:0] f_next_s;
    logic             ovf_next_s;
    logic             vout_next_s;

    // Stage 1: capture operands and qualifier every cycle, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= {IN_W{1'b0}};
            b_r <= {IN_W{1'b0}};
            v_r <= 1'b0;
        end else begin
            a_r <= a;
            b_r <= b;
            v_r <= valid_in;
        end
    end

    // Stage 2 next-state: accumulate when a sample is held in stage 1
    always_comb begin
        prod_s      = mul_ext(a_r, b_r);
        sum_s       = f_r + prod_s;
        add_ovf_s   = add_ovf(f_r, prod_s, sum_s);
        f_next_s    = f_r;
        ovf_next_s  = ovf_r;
        vout_next_s = 1'b0;
        if (v_r) begin
            vout_next_s = 1'b1;
            ovf_next_s  = ovf_r | add_ovf_s;
`ifdef MAC_SATURATE_EN
            if (add_ovf_s) begin
                f_next_s = sat_value(f_r[ACC_W-1]);
            end else begin
                f_next_s = sum_s;
            end
`else
            f_next_s = sum_s;
`endif
        end else begin
            f_next_s    = f_r;
            ovf_next_s  = ovf_r;
            vout_next_s = 1'b0;
        end
    end

    // Stage 2 registers: accumulator, sticky flag and output qualifier
    always_ff @(posedge clk) begin
        if (reset) begin
            f_r    <= {ACC_W{1'b0}};
            ovf_r  <= 1'b0;
            vout_r <= 1'b0;
        end else begin
            f_r    <= f_next_s;
            ovf_r  <= ovf_next_s;
            vout_r <= vout_next_s;
        end
    end

    assign f         = f_r;
    assign overflow  = ovf_r;
    assign valid_out = vout_r;

endmodule

// File: tb/tb_ff_comb.sv
// ---------------------------------------------------------------------------
// tb_ff_comb : self-checking bench for ff_comb (IN_W=8, ACC_W=16)
//
// A reference model runs when each sample is driven and pushes the expected
// accumulator/flag onto a queue. A monitor pops one entry per valid_out pulse.
// The scenario tasks also check the exact values listed in the test plan,
// including the cycles where valid_out must stay low.
// ---------------------------------------------------------------------------
module tb_ff_comb;

    localparam int IN_W  = 8;
    localparam int ACC_W = 16;

    logic             clk;
    logic             reset;
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic             valid_in;
    logic             valid_out;
    logic [ACC_W-1:0] f;
    logic             overflow;

    int ntests;
    int nfail;

    typedef struct {
        logic [ACC_W-1:0] f;
        logic             ovf;
    } exp_t;

    exp_t   sb_q[$];
    longint m_acc;
    bit     m_ovf;

    ff_comb #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .valid_out (valid_out),
        .f         (f),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and update the reference model. Returns 1
    // time unit after the edge that samples it.
    task automatic cyc(input int ai, input int bi, input bit vi, input bit ri);
        longint raw;
        longint w;
        exp_t   e;
        #2;
        a        = 8'(ai);
        b        = 8'(bi);
        valid_in = vi;
        reset    = ri;
        if (ri) begin
            m_acc = 0;
            m_ovf = 1'b0;
            sb_q.delete();
        end else if (vi) begin
            raw = m_acc + longint'(ai) * longint'(bi);
            w   = raw;
            if (raw > 32767 || raw < -32768) m_ovf = 1'b1;
`ifdef MAC_SATURATE_EN
            if (raw > 32767) w = 32767;
            else if (raw < -32768) w = -32768;
`else
            if (raw > 32767) w = raw - 65536;
            else if (raw < -32768) w = raw + 65536;
`endif
            m_acc = w;
            e.f   = 16'(w);
            e.ovf = m_ovf;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid_out pulse consumes one expected entry
    always @(posedge clk) begin
        #1;
        if (valid_out === 1'b1) begin
            ntests++;
            if (sb_q.size() == 0) begin
                nfail++;
                $display("FAIL sb_unexpected_valid: valid_out=1 with no sample pending, f=%0d", $signed(f));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (f !== e.f) begin
                    nfail++;
                    $display("FAIL sb_f: got %0d expected %0d", $signed(f), $signed(e.f));
                end
                ntests++;
                if (overflow !== e.ovf) begin
                    nfail++;
                    $display("FAIL sb_overflow: got %0b expected %0b", overflow, e.ovf);
                end
            end
        end
    end

    task automatic test_reset();
        cyc(5, 7, 1'b1, 1'b1);
        ntests++;
        if (valid_out !== 1'b0) begin nfail++; $display("FAIL reset_valid_out: got %0b expected 0", valid_out); end
        ntests++;
        if (f !== 16'h0000) begin nfail++; $display("FAIL reset_f: got %0d expected 0", $signed(f)); end
        ntests++;
        if (overflow !== 1'b0) begin nfail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_basic();
        int sa [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
        bit sv [8] = '{0, 0, 1, 1, 0, 0, 1, 0};
        bit ev [8] = '{0, 0, 0, 1, 1, 0, 0, 1};
        int ef [8] = '{0, 0, 0, 4, 13, 13, 13, 49};
        logic [ACC_W-1:0] fx;
        for (int i = 0; i < 8; i++) begin
            cyc(sa[i], sa[i], sv[i], (i == 0));
            fx = 16'(ef[i]);
            ntests++;
            if (valid_out !== ev[i]) begin nfail++; $display("FAIL basic_valid_out[%0d]: got %0b expected %0b", i, valid_out, ev[i]); end
            ntests++;
            if (f !== fx) begin nfail++; $display("FAIL basic_f[%0d]: got %0d expected %0d", i, $signed(f), ef[i]); end
            ntests++;
            if (overflow !== 1'b0) begin nfail++; $display("FAIL basic_overflow[%0d]: got %0b expected 0", i, overflow); end
        end
    endtask

    // Reset, then stream a*b; check f/overflow after each of the first 5 edges
    task automatic run_stream(input string nm, input int ai, input int bi,
                              input int ef [5], input bit eo [5]);
        logic [ACC_W-1:0] fx;
        cyc(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(ai, bi, 1'b1, 1'b0);
            fx = 16'(ef[i]);
            ntests++;
            if (valid_out !== (i != 0)) begin nfail++; $display("FAIL %s_valid_out[%0d]: got %0b expected %0b", nm, i, valid_out, (i != 0)); end
            ntests++;
            if (f !== fx) begin nfail++; $display("FAIL %s_f[%0d]: got %0d expected %0d", nm, i, $signed(f), ef[i]); end
            ntests++;
            if (overflow !== eo[i]) begin nfail++; $display("FAIL %s_overflow[%0d]: got %0b expected %0b", nm, i, overflow, eo[i]); end
        end
    endtask

    task automatic test_neg_overflow();
`ifdef MAC_SATURATE_EN
        run_stream("neg_ovf", -100, 120, '{0, -12000, -24000, -32768, -32768}, '{0, 0, 0, 1, 1});
`else
        run_stream("neg_ovf", -100, 120, '{0, -12000, -24000, 29536, 17536}, '{0, 0, 0, 1, 1});
`endif
    endtask

    // Continues the -100*120 stream (overflow already set) into a reset
    task automatic test_reset_mid();
        cyc(-100, 120, 1'b1, 1'b1);
        ntests++;
        if (valid_out !== 1'b0 || f !== 16'h0000 || overflow !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid_clear: got v=%0b f=%0d ovf=%0b expected v=0 f=0 ovf=0", valid_out, $signed(f), overflow);
        end
        cyc(-100, 120, 1'b1, 1'b0);
        ntests++;
        if (valid_out !== 1'b0 || f !== 16'h0000) begin
            nfail++;
            $display("FAIL rst_mid_edge1: got v=%0b f=%0d expected v=0 f=0", valid_out, $signed(f));
        end
        cyc(-100, 120, 1'b1, 1'b0);
        ntests++;
        if (valid_out !== 1'b1 || f !== 16'hD120 || overflow !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid_edge2: got v=%0b f=%0d ovf=%0b expected v=1 f=-12000 ovf=0", valid_out, $signed(f), overflow);
        end
    endtask

    task automatic test_pos_overflow();
`ifdef MAC_SATURATE_EN
        run_stream("pos_ovf", 127, 127, '{0, 16129, 32258, 32767, 32767}, '{0, 0, 0, 1, 1});
`else
        run_stream("pos_ovf", 127, 127, '{0, 16129, 32258, -17149, -1020}, '{0, 0, 0, 1, 1});
`endif
    endtask

    task automatic test_corner();
`ifdef MAC_SATURATE_EN
        run_stream("corner", -128, -128, '{0, 16384, 32767, 32767, 32767}, '{0, 0, 1, 1, 1});
`else
        run_stream("corner", -128, -128, '{0, 16384, -32768, -16384, 0}, '{0, 0, 1, 1, 1});
`endif
    endtask

    // Back-to-back random traffic with occasional resets, scoreboard-checked
    task automatic test_back_to_back();
        cyc(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            cyc(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                ($urandom_range(3) != 0), ($urandom_range(49) == 0));
        end
        cyc(0, 0, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 1'b0);
        ntests++;
        if (sb_q.size() != 0) begin
            nfail++;
            $display("FAIL sb_drain: %0d samples never produced valid_out, expected 0", sb_q.size());
        end
    endtask

    initial begin
        ntests   = 0;
        nfail    = 0;
        m_acc    = 0;
        m_ovf    = 1'b0;
        reset    = 1'b1;
        valid_in = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        test_reset();
        test_basic();
        test_neg_overflow();
        test_reset_mid();
        test_pos_overflow();
        test_corner();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/ff_comb.md
Name:
ff_comb

Overview:
- Two-stage pipelined signed multiply-accumulate (MAC) unit.
- Each valid input pair a*b is added into a running accumulator f.
- Signed overflow of the accumulator is reported on a sticky flag.
- Used as a streaming datapath leaf block with a simple valid-in / valid-out qualifier.

Parameters:
- IN_W, 8, width of signed operands a and b.
- ACC_W, 16, width of signed accumulator/output f; must satisfy ACC_W >= 2*IN_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- a  input  IN_W  signed multiplicand (two's complement)
- b  input  IN_W  signed multiplier (two's complement)
- valid_in  input  1  a/b qualify as a sample this cycle
- valid_out  output  1  f was updated by a sample on the last edge
- f  output  ACC_W  signed accumulator value (registered)
- overflow  output  1  sticky signed-overflow flag (registered)

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. reset=1 at an edge clears a_r, b_r, v_r, f, overflow and valid_out to 0. Reset has priority over all other activity.
- Stage 1, every non-reset edge: a_r<=a, b_r<=b, v_r<=valid_in. No enable; a and b are always captured.
- Stage 2 when v_r=1:
  - prod = a_r*b_r as a full 2*IN_W signed product, sign-extended to ACC_W.
  - sum = f + prod, wrapping modulo 2^ACC_W.
  - f<=sum and valid_out<=1.
  - overflow <= overflow OR (sign(prod)==sign(f) AND sign(sum)!=sign(f)).
- Stage 2 when v_r=0: f holds, overflow holds, valid_out<=0.
- Latency: a sample present before edge N is captured at edge N. f and valid_out reflect it after edge N+1.
- Throughput: one sample per cycle; back-to-back valids accumulate consecutively.
- Overflow is sticky: it stays 1 until reset and is never cleared by non-overflowing adds.
- Reset mid-stream: any sample held in stage 1 is discarded. The first valid_out after reset corresponds to the first valid_in sampled with reset=0.
- No backpressure; valid_out is a one-cycle pulse per accepted sample.
- Extremes: (-128)*(-128)=+16384 is representable; accumulator wrap is the only overflow source.

Optional Feature:
- Macro MAC_SATURATE_EN.
- Defined: when an add overflows, f is clamped to +2^(ACC_W-1)-1 for positive overflow or -2^(ACC_W-1) for negative overflow instead of wrapping. Overflow detection uses the unclamped sum, and the overflow flag behaves identically.
- Not defined: f wraps modulo 2^ACC_W as specified above.

Test Plan:
- Basic accumulate with gaps:
  - Stimulus: reset for 1 edge, then one pair per edge: (1,1,v=0), (2,2,v=1), (3,3,v=1), (4,4,v=0), (5,5,v=0), (6,6,v=1).
  - Response after 1st–3rd edges: valid_out=0, f=0.
  - After 4th edge: valid_out=1, f=4. After 5th: valid_out=1, f=13.
  - After 6th and 7th: valid_out=0, f=13. After 8th: valid_out=1, f=49. overflow stays 0 throughout.
- Negative overflow (wrap mode):
  - Stimulus: a=-100, b=120, valid_in held 1.
  - Response: f = -12000, -24000, then 29536 with overflow=1, then 17536 with overflow still 1.
- Positive overflow (wrap mode):
  - Stimulus: a=127, b=127 continuous.
  - Response: f = 16129, 32258, then -17149 with overflow=1.
- Corner operand:
  - Stimulus: a=-128, b=-128 continuous.
  - Response: f=16384 with no overflow, then f=-32768 with overflow=1.
- Reset mid-stream:
  - Stimulus: during the -100*120 stream with overflow=1, assert reset for 1 edge.
  - Response: f=0, overflow=0, valid_out=0 after that edge. Two edges after reset is released, f=-12000 and valid_out=1.
- MAC_SATURATE_EN defined:
  - Stimulus: a=-100, b=120 continuous.
  - Response: f = -12000, -24000, then -32768 with overflow=1; f remains -32768 on further samples.
